// File: rtl/hilo_div_ctrl_if.sv
// Divider-side bus: operand/start from the controller, results/busy back from the divider.
`timescale 1ns/1ps
interface hilo_div_ctrl_if;
  logic        div_execute;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_busy;

  modport master (
    output div_execute,
    output div_dividend,
    output div_divisor,
    input  div_quotient,
    input  div_remainder,
    input  div_busy
  );

  modport slave (
    input  div_execute,
    input  div_dividend,
    input  div_divisor,
    output div_quotient,
    output div_remainder,
    output div_busy
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO register unit and divide sequencer sitting between EX and an iterative divider.
// The timer is 7 bits, so both timeouts must be 127 or less.
`timescale 1ns/1ps
module hilo_div_ctrl #(
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned DONE_TIMEOUT  = 96
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic [2:0]              op_code,
  input  logic [31:0]             rs_val,
  input  logic [31:0]             rt_val,
  output logic                    stall,
  output logic [31:0]             hi,
  output logic [31:0]             lo,
  hilo_div_ctrl_if.master         div,
  output logic                    timeout_err
);

  localparam logic [2:0] OpDiv  = 3'd1;
  localparam logic [2:0] OpMthi = 3'd2;
  localparam logic [2:0] OpMtlo = 3'd3;

  localparam logic [6:0] StartLast = 7'(START_TIMEOUT - 1);
  localparam logic [6:0] DoneLast  = 7'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone,
    StSettle,
    StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  timer_q, timer_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        div_execute;

  // State, timer, HI/LO and latched operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  // Op acceptance, divide sequencing and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    div_execute = 1'b0;
    timeout_err = 1'b0;
    stall       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (op_valid) begin
          case (op_code)
            OpDiv: begin
              if (rt_val != '0) begin
                dividend_d = rs_val;
                divisor_d  = rt_val;
                state_d    = StIssue;
                stall      = 1'b1;
              end else begin
                // Divide by zero resolves in place without touching the divider.
                hi_d = rs_val;
                lo_d = '1;
              end
            end
            OpMthi:  hi_d = rs_val;
            OpMtlo:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StIssue: begin
        div_execute = 1'b1;
        timer_d     = '0;
        state_d     = StWaitStart;
      end
      StWaitStart: begin
        if (div.div_busy) begin
          timer_d = '0;
          state_d = StWaitDone;
        end else if (timer_q == StartLast) begin
          state_d = StAbort;
        end else begin
          timer_d = timer_q + 7'd1;
        end
      end
      StWaitDone: begin
        if (!div.div_busy) begin
          state_d = StSettle;
        end else if (timer_q == DoneLast) begin
          state_d = StAbort;
        end else begin
          timer_d = timer_q + 7'd1;
        end
      end
      StSettle: begin
        // Divider results become valid one edge after busy falls.
        lo_d    = div.div_quotient;
        hi_d    = div.div_remainder;
        state_d = StIdle;
      end
      StAbort: begin
        timeout_err = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign hi               = hi_q;
  assign lo               = lo_q;
  assign div.div_execute  = div_execute;
  assign div.div_dividend = dividend_q;
  assign div.div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural iterative divider model.
`timescale 1ns/1ps
module tb_hilo_div_ctrl;

  localparam int START_TIMEOUT = 4;
  localparam int DONE_TIMEOUT  = 96;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;

  hilo_div_ctrl_if div_if ();

  hilo_div_ctrl #(
    .START_TIMEOUT (START_TIMEOUT),
    .DONE_TIMEOUT  (DONE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo),
    .div         (div_if),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Divider model: 0 normal, 1 busy stuck low, 2 busy stuck high.
  int          mode = 0;
  int          iter = 64;
  int          cnt;
  logic        pend;
  logic [31:0] opa, opb;
  int          exec_cnt = 0;

  always @(posedge clk) if (div_if.div_execute) exec_cnt <= exec_cnt + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_if.div_busy      <= 1'b0;
      div_if.div_quotient  <= '0;
      div_if.div_remainder <= '0;
      cnt  <= 0;
      pend <= 1'b0;
      opa  <= '0;
      opb  <= '0;
    end else if (mode == 1) begin
      div_if.div_busy <= 1'b0;
      cnt  <= 0;
      pend <= 1'b0;
    end else if (mode == 2) begin
      div_if.div_busy <= 1'b1;
      cnt <= 0;
    end else if (div_if.div_busy) begin
      if (cnt <= 1) begin
        div_if.div_busy <= 1'b0;
        pend <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (pend) begin
      if (opb != '0) begin
        div_if.div_quotient  <= $signed(opa) / $signed(opb);
        div_if.div_remainder <= $signed(opa) % $signed(opb);
      end
      pend <= 1'b0;
    end else if (div_if.div_execute) begin
      div_if.div_busy <= 1'b1;
      cnt <= iter;
      opa <= div_if.div_dividend;
      opb <= div_if.div_divisor;
    end
  end

  // Architectural HI/LO as seen by software.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic        is_long;
    int          start_exec, cycles;
    sa = a;
    sb = b;
    is_long = (code == 3'd1) && (b != '0);
    case (code)
      3'd1: begin
        if (b == '0) begin
          exp_hi = a;
          exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      3'd2:    exp_hi = a;
      3'd3:    exp_lo = a;
      default: ;
    endcase
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    rs_val   = a;
    rt_val   = b;
    #1;
    chk("stall_on_request", 32'(stall), 32'(is_long));
    start_exec = exec_cnt;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    cycles   = 0;
    while (stall && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("stall_cycles", 32'(cycles), is_long ? 32'(iter + 3) : 32'd0);
    chk("exec_pulses", 32'(exec_cnt - start_exec), 32'(is_long));
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
  endtask

  initial begin
    int          cycles, start_exec, sel;
    logic [31:0] a, b;
    reset    = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    rs_val   = '0;
    rt_val   = '0;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_exec", 32'(div_if.div_execute), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_dividend", div_if.div_dividend, 32'd0);
    chk("rst_divisor", div_if.div_divisor, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed divides, divide-by-zero and moves.
    issue_op(3'd1, 32'd7, 32'd2);
    issue_op(3'd1, 32'hFFFF_FFF9, 32'd2);
    issue_op(3'd1, 32'd100, 32'hFFFF_FFF9);
    issue_op(3'd1, 32'h1234_5678, 32'd0);
    issue_op(3'd2, 32'hAAAA_5555, 32'd0);
    issue_op(3'd3, 32'h0F0F_0F0F, 32'd0);

    // Back-to-back MTHI then MTLO with no gap.
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd2; rs_val = 32'h1111_2222;
    @(posedge clk); #1;
    chk("b2b_hi", hi, 32'h1111_2222);
    chk("b2b_stall0", 32'(stall), 32'd0);
    op_code = 3'd3; rs_val = 32'h3333_4444;
    @(posedge clk); #1;
    chk("b2b_lo", lo, 32'h3333_4444);
    chk("b2b_hi_kept", hi, 32'h1111_2222);
    chk("b2b_stall1", 32'(stall), 32'd0);
    op_valid = 1'b0; op_code = 3'd0;
    exp_hi = 32'h1111_2222;
    exp_lo = 32'h3333_4444;

    // MTLO held by upstream during a divide is taken only after IDLE resumes.
    iter = 10;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd50; rt_val = 32'd7;
    @(posedge clk); #1;
    op_code = 3'd3; rs_val = 32'h0F0F_0F0F;
    cycles = 0;
    while (stall && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("held_div_lo", lo, 32'd7);
    chk("held_div_hi", hi, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    chk("held_mtlo_lo", lo, 32'h0F0F_0F0F);
    chk("held_mtlo_hi", hi, 32'd1);
    exp_hi = 32'd1;
    exp_lo = 32'h0F0F_0F0F;

    // Busy never rises: abort from the start wait.
    mode = 1;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd11; rt_val = 32'd4;
    start_exec = exec_cnt;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    cycles = 0;
    while (!timeout_err && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("start_to_cycles", 32'(cycles), 32'(START_TIMEOUT + 1));
    chk("start_to_hi", hi, exp_hi);
    chk("start_to_lo", lo, exp_lo);
    chk("start_to_exec", 32'(exec_cnt - start_exec), 32'd1);
    @(posedge clk); #1;
    chk("start_to_pulse", 32'(timeout_err), 32'd0);
    chk("start_to_idle", 32'(stall), 32'd0);

    // Busy never falls: abort from the done wait.
    mode = 2;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd13; rt_val = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    cycles = 0;
    while (!timeout_err && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("done_to_cycles", 32'(cycles), 32'(DONE_TIMEOUT + 2));
    chk("done_to_hi", hi, exp_hi);
    chk("done_to_lo", lo, exp_lo);
    @(posedge clk); #1;
    chk("done_to_pulse", 32'(timeout_err), 32'd0);
    chk("done_to_idle", 32'(stall), 32'd0);
    mode = 0;
    repeat (4) @(posedge clk);

    // Reset asserted mid-divide.
    iter = 64;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; rs_val = 32'd50; rt_val = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    repeat (20) @(posedge clk);
    #2;
    chk("mid_stall_high", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_exec", 32'(div_if.div_execute), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    issue_op(3'd1, 32'd9, 32'd3);

    // Random mix against the reference.
    for (int i = 0; i < 12; i++) begin
      sel  = int'($urandom_range(0, 4));
      a    = $urandom;
      b    = $urandom;
      iter = int'($urandom_range(1, 64));
      if (b == '0) b = 32'd1;
      if (b == 32'hFFFF_FFFF) b = 32'd5;
      case (sel)
        0:       issue_op(3'd1, a, b);
        1:       issue_op(3'd1, a, 32'd0);
        2:       issue_op(3'd2, a, b);
        3:       issue_op(3'd3, a, b);
        default: issue_op(3'(4 + $urandom_range(0, 3)), a, b);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- HI/LO register unit and divide sequencer between the EX stage and the 32-bit signed iterative divider.
- Accepts DIV/MTHI/MTLO ops from EX and holds the pipeline via stall while a divide is in flight.
- Drives the divider with a one-cycle execute pulse and tracks its busy flag.
- Captures quotient into LO and remainder into HI; HI/LO feed MFHI/MFLO in EX.

Parameters:
START_TIMEOUT, 4, max cycles in WAIT_START for div_busy to rise before abort.
DONE_TIMEOUT, 96, max cycles in WAIT_DONE for div_busy to fall before abort.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
op_valid  input  1  EX presents an op this cycle.
op_code  input  3  0=NOP, 1=DIV, 2=MTHI, 3=MTLO, 4-7 treated as NOP.
rs_val  input  32  dividend / MTHI / MTLO source.
rt_val  input  32  divisor.
stall  output  1  hold EX and earlier stages.
hi  output  32  HI register (remainder).
lo  output  32  LO register (quotient).
div_execute  output  1  one-cycle start pulse to divider.
div_dividend  output  32  latched dividend, stable from ISSUE until IDLE.
div_divisor  output  32  latched divisor, stable from ISSUE until IDLE.
div_quotient  input  32  divider quotient, registered in divider.
div_remainder  input  32  divider remainder, registered in divider.
div_busy  input  1  high while divider iterates.
timeout_err  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi, lo, div_dividend, div_divisor = 0; div_execute=0; timeout_err=0; stall=0; timer=0. Reset mid-divide returns to IDLE immediately; no HI/LO write.
- Ops are accepted only in IDLE with op_valid=1; op_valid in any other state is ignored.
- MTHI/MTLO: hi<=rs_val or lo<=rs_val at the accepting edge; state stays IDLE; no stall.
- DIV, rt_val==0: no divider start. At the accepting edge hi<=rs_val, lo<=32'hFFFFFFFF. State stays IDLE; no stall.
- DIV, rt_val!=0: latch operands into div_dividend/div_divisor and go to ISSUE.
- stall (combinational) = (state!=IDLE) | (state==IDLE & op_valid & op_code==1 & rt_val!=0).
- States:
  - ISSUE: div_execute=1 (decoded from state), timer cleared; next WAIT_START.
  - WAIT_START: if div_busy go WAIT_DONE with timer cleared; else if timer==START_TIMEOUT-1 go ABORT; else timer++.
  - WAIT_DONE: if !div_busy go SETTLE; else if timer==DONE_TIMEOUT-1 go ABORT; else timer++.
  - SETTLE: wait one cycle, because the divider registers its results on the edge after busy falls. At the end of SETTLE, lo<=div_quotient and hi<=div_remainder; next IDLE.
  - ABORT: timeout_err=1 for this cycle; hi/lo unchanged; next IDLE.
- div_execute is never high outside ISSUE; exactly one pulse per divide.
- Timer is 7 bits wide; both timeouts must be ≤127.
- No arithmetic on data: values pass through as 32-bit two's complement.
- Latency with a 64-iteration divider: accept edge to HI/LO valid = 1 (ISSUE) + ~1 (WAIT_START) + 64 (WAIT_DONE) + 1 (SETTLE) cycles. stall falls in the cycle after the SETTLE write.
- MTHI/MTLO/DIV presented while stall=1 are held by upstream and accepted once IDLE resumes.

Test Plan:
- Reset, then DIV rs=7 rt=2 against the divider model -> one div_execute pulse; stall high throughout; after SETTLE lo=3, hi=1, stall=0.
- DIV rs=-7 (0xFFFFFFF9) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV rs=100 rt=-7 -> lo=0xFFFFFFF2, hi=2.
- DIV rs=0x12345678 rt=0 -> no div_execute, stall never high; next cycle hi=0x12345678, lo=0xFFFFFFFF.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F on consecutive cycles -> hi/lo updated at each edge, stall=0; MTLO issued during a DIV is not accepted until IDLE, and lo then equals 0x0F0F0F0F.
- Model with div_busy stuck 0 -> timeout_err pulses 1 cycle after START_TIMEOUT cycles in WAIT_START; hi/lo unchanged; IDLE. Repeat with busy stuck 1 -> abort after DONE_TIMEOUT.
- Assert reset mid-WAIT_DONE -> stall, div_execute, hi, lo all 0 asynchronously; a subsequent DIV 9/3 completes with lo=3, hi=0.
